// File: rtl/custom_axi_regif_if.sv
// AXI4-Lite slave-side bundle for the register front end.
interface custom_axi_regif_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) ();
    logic [ADDR_W-1:0]   s_awaddr_i;
    logic                s_awvalid_i;
    logic                s_awready_o;
    logic [DATA_W-1:0]   s_wdata_i;
    logic [DATA_W/8-1:0] s_wstrb_i;
    logic                s_wvalid_i;
    logic                s_wready_o;
    logic [1:0]          s_bresp_o;
    logic                s_bvalid_o;
    logic                s_bready_i;
    logic [ADDR_W-1:0]   s_araddr_i;
    logic                s_arvalid_i;
    logic                s_arready_o;
    logic [DATA_W-1:0]   s_rdata_o;
    logic [1:0]          s_rresp_o;
    logic                s_rvalid_o;
    logic                s_rready_i;

    modport slave (
        input  s_awaddr_i, s_awvalid_i, s_wdata_i, s_wstrb_i, s_wvalid_i, s_bready_i,
        input  s_araddr_i, s_arvalid_i, s_rready_i,
        output s_awready_o, s_wready_o, s_bresp_o, s_bvalid_o,
        output s_arready_o, s_rdata_o, s_rresp_o, s_rvalid_o
    );

    modport master (
        output s_awaddr_i, s_awvalid_i, s_wdata_i, s_wstrb_i, s_wvalid_i, s_bready_i,
        output s_araddr_i, s_arvalid_i, s_rready_i,
        input  s_awready_o, s_wready_o, s_bresp_o, s_bvalid_o,
        input  s_arready_o, s_rdata_o, s_rresp_o, s_rvalid_o
    );
endinterface

// File: rtl/custom_axi_regif.sv
// AXI4-Lite register front end: write shadows with one-cycle strobes toward the IP,
// read shadows captured from the IP, independent read and write channels.
module custom_axi_regif #(
    parameter int unsigned NUM_REGS = 3,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    custom_axi_regif_if.slave            s_axi,
    output logic [NUM_REGS*DATA_W-1:0]   reg2ip_data_o,
    output logic [NUM_REGS-1:0]          reg2ip_en_o,
    input  logic [NUM_REGS*DATA_W-1:0]   ip2reg_data_i,
    input  logic [NUM_REGS-1:0]          ip2reg_en_i
);
    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SH_W   = NUM_REGS * DATA_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_EXEC = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    // write channel state
    logic [1:0]        w_state_q, w_state_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [SH_W-1:0]   wshadow_q, wshadow_d;
    logic [NUM_REGS-1:0] reg2ip_en_q, reg2ip_en_d;

    // read channel state
    logic [0:0]        r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [SH_W-1:0]   rshadow_q, rshadow_d;

    // combinational helpers
    logic              aw_hs_c, w_hs_c, ar_hs_c;
    logic [ADDR_W-1:0] eff_awaddr_c;
    logic [DATA_W-1:0] eff_wdata_c;
    logic [STRB_W-1:0] eff_wstrb_c;
    logic [IDX_W-1:0]  aw_idx_c, ar_idx_c;
    logic              aw_in_range_c, ar_in_range_c;
    logic [DATA_W-1:0] rd_sel_c;
    logic              unused_addr_lsbs_c;

    assign unused_addr_lsbs_c = ^{s_axi.s_awaddr_i[1:0], s_axi.s_araddr_i[1:0]};

    assign aw_hs_c = s_axi.s_awvalid_i & awready_q;
    assign w_hs_c  = s_axi.s_wvalid_i & wready_q;
    assign ar_hs_c = s_axi.s_arvalid_i & arready_q;

    // a beat arriving this cycle takes precedence over the held copy
    assign eff_awaddr_c = aw_hs_c ? s_axi.s_awaddr_i : awaddr_q;
    assign eff_wdata_c  = w_hs_c  ? s_axi.s_wdata_i  : wdata_q;
    assign eff_wstrb_c  = w_hs_c  ? s_axi.s_wstrb_i  : wstrb_q;

    assign aw_idx_c      = eff_awaddr_c[ADDR_W-1:2];
    assign ar_idx_c      = s_axi.s_araddr_i[ADDR_W-1:2];
    assign aw_in_range_c = (aw_idx_c < IDX_W'(NUM_REGS));
    assign ar_in_range_c = (ar_idx_c < IDX_W'(NUM_REGS));

    // read shadow selected by the AR index; zero when out of range
    always_comb begin
        rd_sel_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ar_idx_c == IDX_W'(i)) begin
                rd_sel_c = rshadow_q[i*DATA_W +: DATA_W];
            end
        end
    end

    // write FSM next state, byte merge and strobe generation
    always_comb begin
        w_state_d   = w_state_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        wshadow_d   = wshadow_q;
        reg2ip_en_d = '0;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_c) begin
                    aw_held_d = 1'b1;
                    awready_d = 1'b0;
                    awaddr_d  = s_axi.s_awaddr_i;
                end
                if (w_hs_c) begin
                    w_held_d = 1'b1;
                    wready_d = 1'b0;
                    wdata_d  = s_axi.s_wdata_i;
                    wstrb_d  = s_axi.s_wstrb_i;
                end
                if ((aw_held_q | aw_hs_c) & (w_held_q | w_hs_c)) begin
                    w_state_d = W_EXEC;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bresp_d   = aw_in_range_c ? RESP_OKAY : RESP_SLVERR;
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (aw_idx_c == IDX_W'(i)) begin
                            reg2ip_en_d[i] = 1'b1;
                            for (int unsigned b = 0; b < STRB_W; b++) begin
                                if (eff_wstrb_c[b]) begin
                                    wshadow_d[i*DATA_W + b*8 +: 8] = eff_wdata_c[b*8 +: 8];
                                end
                            end
                        end
                    end
                end
            end
            W_EXEC: begin
                w_state_d = W_RESP;
                bvalid_d  = 1'b1;
            end
            W_RESP: begin
                if (s_axi.s_bready_i) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
                wready_d  = 1'b1;
            end
        endcase
    end

    // read FSM next state; data is latched from pre-capture shadows
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_c) begin
                    r_state_d = R_RESP;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_sel_c;
                    rresp_d   = ar_in_range_c ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_RESP: begin
                if (s_axi.s_rready_i) begin
                    r_state_d = R_IDLE;
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    // read shadow capture from the IP
    always_comb begin
        rshadow_d = rshadow_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ip2reg_en_i[i]) begin
                rshadow_d[i*DATA_W +: DATA_W] = ip2reg_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // state registers; reset aborts any transaction in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_q   <= W_IDLE;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awready_q   <= 1'b1;
            wready_q    <= 1'b1;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            wshadow_q   <= '0;
            reg2ip_en_q <= '0;
            r_state_q   <= R_IDLE;
            arready_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            rshadow_q   <= '0;
        end else begin
            w_state_q   <= w_state_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            wshadow_q   <= wshadow_d;
            reg2ip_en_q <= reg2ip_en_d;
            r_state_q   <= r_state_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            rshadow_q   <= rshadow_d;
        end
    end

    assign s_axi.s_awready_o = awready_q;
    assign s_axi.s_wready_o  = wready_q;
    assign s_axi.s_bvalid_o  = bvalid_q;
    assign s_axi.s_bresp_o   = bresp_q;
    assign s_axi.s_arready_o = arready_q;
    assign s_axi.s_rvalid_o  = rvalid_q;
    assign s_axi.s_rresp_o   = rresp_q;
    assign s_axi.s_rdata_o   = rdata_q;
    assign reg2ip_data_o     = wshadow_q;
    assign reg2ip_en_o       = reg2ip_en_q;

endmodule

// File: tb/tb_custom_axi_regif.sv
// Randomized bench for custom_axi_regif against a register-array reference model.
module tb_custom_axi_regif;
    localparam int unsigned NREG = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [95:0] reg2ip_data;
    logic [2:0]  reg2ip_en;
    logic [95:0] ip2reg_data;
    logic [2:0]  ip2reg_en;

    custom_axi_regif_if #(.ADDR_W(8), .DATA_W(32)) axi ();

    custom_axi_regif #(.NUM_REGS(3), .ADDR_W(8), .DATA_W(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .s_axi         (axi),
        .reg2ip_data_o (reg2ip_data),
        .reg2ip_en_o   (reg2ip_en),
        .ip2reg_data_i (ip2reg_data),
        .ip2reg_en_i   (ip2reg_en)
    );

    always #5 clk_i = ~clk_i;

    // reference model: plain register arrays
    logic [31:0] wsh [NREG];
    logic [31:0] rsh [NREG];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        int          idx;
        bit          inr;
        logic [31:0] cur;
        logic [95:0] exp_vec;
        bit          aw_done, w_done, b_done;
        int          h, nstb, bv_first, bv_cnt;
        idx = int'(addr[7:2]);
        inr = (idx < int'(NREG));
        if (inr) begin
            cur = wsh[idx];
            for (int b = 0; b < 4; b++) if (strb[b]) cur[b*8 +: 8] = data[b*8 +: 8];
            wsh[idx] = cur;
        end
        exp_vec  = {wsh[2], wsh[1], wsh[0]};
        aw_done  = 1'b0; w_done = 1'b0; b_done = 1'b0;
        h        = -100; nstb = 0; bv_first = -1; bv_cnt = 0;
        axi.s_awaddr_i = addr;
        axi.s_wdata_i  = data;
        axi.s_wstrb_i  = strb;
        for (int cyc = 0; cyc < 64 && !b_done; cyc++) begin
            if (reg2ip_en != 3'b000) begin
                nstb++;
                chk("wr_strobe_bits", 96'(reg2ip_en), inr ? 96'(3'b001 << idx) : 96'(0));
                chk("wr_strobe_cyc", 96'(cyc), 96'(h + 1));
                chk("wr_strobe_data", reg2ip_data, exp_vec);
            end
            if (axi.s_bvalid_o) begin
                if (bv_first < 0) begin
                    bv_first = cyc;
                    chk("wr_bvalid_cyc", 96'(cyc), 96'(h + 2));
                    chk("wr_bresp", 96'(axi.s_bresp_o), inr ? 96'(2'b00) : 96'(2'b10));
                end
                bv_cnt++;
            end
            axi.s_awvalid_i = !aw_done && cyc >= aw_dly;
            axi.s_wvalid_i  = !w_done && cyc >= w_dly;
            axi.s_bready_i  = bv_first >= 0 && (cyc - bv_first) >= b_dly;
            if (axi.s_awvalid_i && axi.s_awready_o) aw_done = 1'b1;
            if (axi.s_wvalid_i && axi.s_wready_o) w_done = 1'b1;
            if (aw_done && w_done && h == -100) h = cyc;
            if (axi.s_bvalid_o && axi.s_bready_i) b_done = 1'b1;
            @(negedge clk_i);
        end
        axi.s_awvalid_i = 1'b0;
        axi.s_wvalid_i  = 1'b0;
        axi.s_bready_i  = 1'b0;
        chk("wr_b_done", 96'(b_done), 96'(1));
        chk("wr_nstrobe", 96'(nstb), 96'(inr));
        chk("wr_bvalid_hold", 96'(bv_cnt), 96'(b_dly + 1));
        chk("wr_ready_back", 96'({axi.s_awready_o, axi.s_wready_o, axi.s_bvalid_o, reg2ip_en}), 96'(6'b110_000));
        chk("wr_shadow", reg2ip_data, exp_vec);
    endtask

    task automatic axi_read(input logic [7:0] addr, input int ar_dly, input int r_dly, input bit cap);
        int          idx;
        bit          inr;
        logic [31:0] exp_d;
        bit          ar_done, r_done;
        int          h, rv_first, rv_cnt;
        idx     = int'(addr[7:2]);
        inr     = (idx < int'(NREG));
        exp_d   = '0;
        ar_done = 1'b0; r_done = 1'b0;
        h       = -100; rv_first = -1; rv_cnt = 0;
        axi.s_araddr_i = addr;
        for (int cyc = 0; cyc < 64 && !r_done; cyc++) begin
            if (axi.s_rvalid_o) begin
                if (rv_first < 0) begin
                    rv_first = cyc;
                    chk("rd_rvalid_cyc", 96'(cyc), 96'(h + 1));
                end
                rv_cnt++;
                chk("rd_rdata", 96'(axi.s_rdata_o), 96'(exp_d));
                chk("rd_rresp", 96'(axi.s_rresp_o), inr ? 96'(2'b00) : 96'(2'b10));
                chk("rd_arready_low", 96'(axi.s_arready_o), 96'(0));
            end
            axi.s_arvalid_i = !ar_done && cyc >= ar_dly;
            axi.s_rready_i  = rv_first >= 0 && (cyc - rv_first) >= r_dly;
            if (axi.s_arvalid_i && axi.s_arready_o) begin
                ar_done = 1'b1;
                h       = cyc;
                exp_d   = inr ? rsh[idx] : 32'h0;
                if (cap && inr) begin
                    ip2reg_en                 = 3'b001 << idx;
                    ip2reg_data[idx*32 +: 32] = ~exp_d;
                    rsh[idx]                  = ~exp_d;
                end
            end
            if (axi.s_rvalid_o && axi.s_rready_i) r_done = 1'b1;
            @(negedge clk_i);
            if (cap) ip2reg_en = 3'b000;
        end
        axi.s_arvalid_i = 1'b0;
        axi.s_rready_i  = 1'b0;
        chk("rd_r_done", 96'(r_done), 96'(1));
        chk("rd_rvalid_hold", 96'(rv_cnt), 96'(r_dly + 1));
        chk("rd_idle_back", 96'({axi.s_arready_o, axi.s_rvalid_o}), 96'(2'b10));
    endtask

    task automatic ip_capture(input logic [2:0] mask, input logic [95:0] vals);
        ip2reg_en   = mask;
        ip2reg_data = vals;
        for (int i = 0; i < int'(NREG); i++) if (mask[i]) rsh[i] = vals[i*32 +: 32];
        @(negedge clk_i);
        ip2reg_en = 3'b000;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_readies"}, 96'({axi.s_awready_o, axi.s_wready_o, axi.s_arready_o}), 96'(3'b111));
        chk({tag, "_valids"}, 96'({axi.s_bvalid_o, axi.s_rvalid_o}), 96'(2'b00));
        chk({tag, "_resps"}, 96'({axi.s_bresp_o, axi.s_rresp_o}), 96'(4'h0));
        chk({tag, "_rdata"}, 96'(axi.s_rdata_o), 96'(0));
        chk({tag, "_reg2ip"}, {reg2ip_data[95:3], reg2ip_en}, 96'(0));
    endtask

    initial begin
        rst_i           = 1'b1;
        axi.s_awaddr_i  = '0; axi.s_awvalid_i = 1'b0;
        axi.s_wdata_i   = '0; axi.s_wstrb_i   = '0; axi.s_wvalid_i = 1'b0;
        axi.s_bready_i  = 1'b0;
        axi.s_araddr_i  = '0; axi.s_arvalid_i = 1'b0; axi.s_rready_i = 1'b0;
        ip2reg_data     = '0; ip2reg_en = '0;
        for (int i = 0; i < int'(NREG); i++) begin wsh[i] = '0; rsh[i] = '0; end
        repeat (3) @(negedge clk_i);
        check_reset_state("reset");
        chk("reset_wshadow", reg2ip_data, 96'(0));
        rst_i = 1'b0;
        @(negedge clk_i);

        // aligned write, AW and W together
        axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("tp_deadbeef", 96'(reg2ip_data[63:32]), 96'(32'hDEADBEEF));

        // byte-lane merge with W leading AW by three cycles
        axi_write(8'h00, 32'h11223344, 4'hF, 0, 0, 1);
        axi_write(8'h00, 32'h0000AB00, 4'h2, 3, 0, 0);
        chk("tp_merge", 96'(reg2ip_data[31:0]), 96'(32'h1122AB44));

        // zero strobe still pulses; back-to-back writes to one register
        axi_write(8'h08, 32'h55AA55AA, 4'h0, 0, 2, 0);
        axi_write(8'h08, 32'h01020304, 4'hF, 1, 0, 0);
        axi_write(8'h09, 32'hFFFF0000, 4'hC, 0, 0, 2);

        // captured value held stable under read back-pressure
        ip_capture(3'b100, {32'hCAFEF00D, 64'h0});
        axi_read(8'h08, 0, 4, 1'b0);

        // out-of-range write and read
        axi_write(8'h0C, 32'h12345678, 4'hF, 0, 0, 0);
        axi_read(8'h0C, 0, 0, 1'b0);
        axi_read(8'hFF, 2, 1, 1'b0);

        // capture in the AR handshake cycle returns the pre-capture value
        axi_read(8'h04, 0, 0, 1'b1);
        axi_read(8'h04, 0, 0, 1'b0);

        // concurrent read and write
        fork
            axi_read(8'h00, 0, 0, 1'b0);
            axi_write(8'h04, 32'h0BADCAFE, 4'hF, 0, 0, 0);
        join

        // reset while a write response is pending
        axi.s_awaddr_i  = 8'h04; axi.s_wdata_i = 32'h77777777; axi.s_wstrb_i = 4'hF;
        axi.s_awvalid_i = 1'b1;  axi.s_wvalid_i = 1'b1; axi.s_bready_i = 1'b0;
        @(negedge clk_i);
        axi.s_awvalid_i = 1'b0;  axi.s_wvalid_i = 1'b0;
        @(negedge clk_i);
        chk("rst_pre_bvalid", 96'(axi.s_bvalid_o), 96'(1));
        #2 rst_i = 1'b1;
        #1;
        check_reset_state("rst_async");
        chk("rst_wshadow", reg2ip_data, 96'(0));
        for (int i = 0; i < int'(NREG); i++) begin wsh[i] = '0; rsh[i] = '0; end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("rst_no_resp", 96'({axi.s_bvalid_o, axi.s_awready_o, reg2ip_en}), 96'(5'b0_1_000));
        end
        axi_read(8'h08, 0, 0, 1'b0);

        // randomized mix
        for (int n = 0; n < 80; n++) begin
            logic [7:0]  wa, ra;
            logic [31:0] wd;
            logic [3:0]  ws;
            int          op;
            op = int'($urandom_range(0, 3));
            wa = 8'($urandom_range(0, 15));
            ra = 8'($urandom_range(0, 15));
            wd = $urandom;
            ws = 4'($urandom);
            case (op)
                0: axi_write(wa, wd, ws, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 3)));
                1: axi_read(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
                2: ip_capture(3'($urandom), {$urandom, $urandom, $urandom});
                default: fork
                    axi_read(ra, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
                    axi_write(wa, wd, ws, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                              int'($urandom_range(0, 3)));
                join
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
